// File: rtl/hilo_ctrl.sv
// hilo_ctrl: HI/LO sequencer for MULT/MULTU/DIV/DIVU/MTHI/MTLO (+MADD/MSUB).
// Latency: single-cycle ops write at N+1; divides write at N+33 (div-by-zero at N+1).
// Backpressure: stall_o holds the pipeline while a divide iterates; start_i ignored when not IDLE.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   start_i, op_i       operation request (sampled only in IDLE)
//   opa_i, opb_i        rs / rt operands
//   cancel_i            flush: abort the in-flight op and suppress its write
//   hi_i, lo_i          current HI/LO contents from hilo_reg
//   stall_o             hold EX and earlier stages
//   hilo_we_o           one-cycle write strobe, with hi_o/lo_o as write data
//
// Optional feature macro: HILO_MADD_EN enables MADD/MSUB (op 110/111).
// Without it those encodings are a NOP (no stall, no write).

module hilo_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] opa_i,
  input  logic [DATA_W-1:0] opb_i,
  input  logic              cancel_i,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  output logic              stall_o,
  output logic              hilo_we_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  // FSM encoding
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_DIV_RUN = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  // Operation encoding
  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef HILO_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MSUB  = 3'b111;
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;

  // Divider working registers: r_quo starts as the dividend magnitude and
  // is shifted left each iteration while quotient bits enter at the LSB.
  logic [DATA_W-1:0] r_quo;
  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_dvs;
  logic              r_q_neg;
  logic              r_r_neg;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic w_idle;
  logic w_accept;
  logic w_is_div;
  logic w_div_signed;
  logic w_dvs_zero;

  assign w_idle       = (r_state == S_IDLE);
  // cancel_i wins over a same-cycle start
  assign w_accept     = w_idle & start_i & ~cancel_i;
  assign w_is_div     = (op_i == OP_DIV) | (op_i == OP_DIVU);
  assign w_div_signed = (op_i == OP_DIV);
  assign w_dvs_zero   = (opb_i == '0);

  // ---------------------------------------------------------------------------
  // Multiplier: one 2W x 2W multiply whose operands are sign- or zero-extended
  // depending on the op; the low 2W bits are the exact signed/unsigned product.
  // ---------------------------------------------------------------------------
  logic                w_ext_sign;
  logic [2*DATA_W-1:0] w_a_ext;
  logic [2*DATA_W-1:0] w_b_ext;
  logic [2*DATA_W-1:0] w_prod;

  assign w_ext_sign = (op_i != OP_MULTU);
  assign w_a_ext    = {{DATA_W{w_ext_sign & opa_i[DATA_W-1]}}, opa_i};
  assign w_b_ext    = {{DATA_W{w_ext_sign & opb_i[DATA_W-1]}}, opb_i};
  assign w_prod     = w_a_ext * w_b_ext;

`ifdef HILO_MADD_EN
  logic [2*DATA_W-1:0] w_acc;
  logic [2*DATA_W-1:0] w_madd;
  logic [2*DATA_W-1:0] w_msub;

  assign w_acc  = {hi_i, lo_i};
  assign w_madd = w_acc + w_prod;
  assign w_msub = w_acc - w_prod;
`endif

  // ---------------------------------------------------------------------------
  // Divider operand capture: magnitudes for DIV, raw values for DIVU
  // ---------------------------------------------------------------------------
  logic              w_a_neg;
  logic              w_b_neg;
  logic [DATA_W-1:0] w_a_mag;
  logic [DATA_W-1:0] w_b_mag;

  assign w_a_neg = w_div_signed & opa_i[DATA_W-1];
  assign w_b_neg = w_div_signed & opb_i[DATA_W-1];
  assign w_a_mag = w_a_neg ? (-opa_i) : opa_i;
  assign w_b_mag = w_b_neg ? (-opb_i) : opb_i;

  // ---------------------------------------------------------------------------
  // Restoring radix-2 step. The partial remainder is always below the divisor,
  // so shifting in one dividend bit needs only one extra bit of headroom and
  // the top bit of the trial difference is the borrow.
  // ---------------------------------------------------------------------------
  logic [DATA_W:0]   w_rem_sh;
  logic [DATA_W:0]   w_diff;
  logic              w_fits;
  logic [DATA_W-1:0] w_rem_nxt;
  logic [DATA_W-1:0] w_quo_nxt;
  logic [DATA_W-1:0] w_quo_fin;
  logic [DATA_W-1:0] w_rem_fin;
  logic              w_last_iter;

  assign w_rem_sh    = {r_rem, r_quo[DATA_W-1]};
  assign w_diff      = w_rem_sh - {1'b0, r_dvs};
  assign w_fits      = ~w_diff[DATA_W];
  assign w_rem_nxt   = w_fits ? w_diff[DATA_W-1:0] : w_rem_sh[DATA_W-1:0];
  assign w_quo_nxt   = {r_quo[DATA_W-2:0], w_fits};
  assign w_last_iter = (r_cnt == CNT_W'(DATA_W - 1));

  // Sign fix-up. The most-negative / -1 case yields magnitude 2^(W-1), whose
  // negation wraps back to itself, which is the intended result.
  assign w_quo_fin = r_q_neg ? (-w_quo_nxt) : w_quo_nxt;
  assign w_rem_fin = r_r_neg ? (-w_rem_nxt) : w_rem_nxt;

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The stall must be visible in the accept cycle itself, before the FSM moves.
  assign stall_o   = (w_accept & w_is_div) | (r_state == S_DIV_RUN);
  // A flush in the write cycle still suppresses the strobe.
  assign hilo_we_o = r_we & ~cancel_i;
  assign hi_o      = r_hi;
  assign lo_o      = r_lo;

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (cancel_i) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start_i) begin
              case (op_i)
                OP_MULT, OP_MULTU: begin
                  r_we <= 1'b1;
                  r_hi <= w_prod[2*DATA_W-1:DATA_W];
                  r_lo <= w_prod[DATA_W-1:0];
                end
                OP_DIV, OP_DIVU: begin
                  if (w_dvs_zero) begin
                    // No iterations: report dividend as remainder, all-ones quotient
                    r_we    <= 1'b1;
                    r_hi    <= opa_i;
                    r_lo    <= '1;
                    r_state <= S_DONE;
                  end else begin
                    r_quo   <= w_a_mag;
                    r_rem   <= '0;
                    r_dvs   <= w_b_mag;
                    r_q_neg <= w_a_neg ^ w_b_neg;
                    r_r_neg <= w_a_neg;
                    r_cnt   <= '0;
                    r_state <= S_DIV_RUN;
                  end
                end
                OP_MTHI: begin
                  r_we <= 1'b1;
                  r_hi <= opa_i;
                  r_lo <= lo_i;
                end
                OP_MTLO: begin
                  r_we <= 1'b1;
                  r_hi <= hi_i;
                  r_lo <= opa_i;
                end
`ifdef HILO_MADD_EN
                OP_MADD: begin
                  r_we <= 1'b1;
                  r_hi <= w_madd[2*DATA_W-1:DATA_W];
                  r_lo <= w_madd[DATA_W-1:0];
                end
                OP_MSUB: begin
                  r_we <= 1'b1;
                  r_hi <= w_msub[2*DATA_W-1:DATA_W];
                  r_lo <= w_msub[DATA_W-1:0];
                end
`endif
                default: begin
                  // unused encodings: no write, no stall
                end
              endcase
            end
          end

          S_DIV_RUN: begin
            r_quo <= w_quo_nxt;
            r_rem <= w_rem_nxt;
            if (w_last_iter) begin
              r_we    <= 1'b1;
              r_hi    <= w_rem_fin;
              r_lo    <= w_quo_fin;
              r_cnt   <= '0;
              r_state <= S_DONE;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end

          S_DONE: begin
            r_state <= S_IDLE;
          end

          default: begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hilo_ctrl.sv
// tb_hilo_ctrl: randomized and directed checks of hilo_ctrl against an arithmetic model.
// Latency: expects writes at N+1 (single-cycle, div-by-zero) or N+33 (divide).
// Backpressure: expects stall_o from accept through N+32 for real divides only.

module tb_hilo_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [2:0]  op_i = '0;
  logic [31:0] opa_i = '0;
  logic [31:0] opb_i = '0;
  logic        cancel_i = 1'b0;
  logic [31:0] hi_i = '0;
  logic [31:0] lo_i = '0;
  logic        stall_o;
  logic        hilo_we_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  hilo_ctrl #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .op_i      (op_i),
    .opa_i     (opa_i),
    .opb_i     (opb_i),
    .cancel_i  (cancel_i),
    .hi_i      (hi_i),
    .lo_i      (lo_i),
    .stall_o   (stall_o),
    .hilo_we_o (hilo_we_o),
    .hi_o      (hi_o),
    .lo_o      (lo_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Architectural result of one op, straight from the arithmetic definitions.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hv, input logic [31:0] lv,
                       output bit wr, output bit divrun,
                       output logic [31:0] eh, output logic [31:0] el);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    wr = 1'b1;
    divrun = 1'b0;
    eh = '0;
    el = '0;
    case (op)
      3'b000: begin p = 64'(sa * sb); eh = p[63:32]; el = p[31:0]; end
      3'b001: begin p = {32'h0, a} * {32'h0, b}; eh = p[63:32]; el = p[31:0]; end
      3'b010, 3'b011: begin
        if (b == 32'h0) begin
          eh = a;
          el = 32'hFFFF_FFFF;
        end else begin
          divrun = 1'b1;
          if (op == 3'b010) begin
            q = sa / sb;
            r = sa % sb;
            p = 64'(q); el = p[31:0];
            p = 64'(r); eh = p[31:0];
          end else begin
            el = a / b;
            eh = a % b;
          end
        end
      end
      3'b100: begin eh = a;  el = lv; end
      3'b101: begin eh = hv; el = a;  end
      default: begin
`ifdef HILO_MADD_EN
        if (op == 3'b110) p = {hv, lv} + 64'(sa * sb);
        else              p = {hv, lv} - 64'(sa * sb);
        eh = p[63:32];
        el = p[31:0];
`else
        wr = 1'b0;
`endif
      end
    endcase
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'($urandom_range(0, 20));
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issue one op at cycle N and check every cycle through the write window.
  // cancel_at: -1 none, 0 same cycle as start, k>0 at cycle N+k.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hv, input logic [31:0] lv, input int cancel_at);
    bit          wr, divrun, accepted, is_div;
    logic [31:0] eh, el;
    int          wc, busy_end, window;
    bit          exp_stall, exp_we, busy;

    model(op, a, b, hv, lv, wr, divrun, eh, el);
    accepted = (cancel_at != 0);
    is_div   = (op == 3'b010) || (op == 3'b011);
    wc       = (!accepted || !wr) ? 0 : (divrun ? 33 : 1);
    if (cancel_at > 0 && cancel_at <= wc) wc = 0;
    busy_end = !accepted ? 0 : (divrun ? 33 : ((is_div) ? 1 : 0));
    window   = divrun ? 35 : 3;

    @(negedge clk);
    start_i  = 1'b1;
    op_i     = op;
    opa_i    = a;
    opb_i    = b;
    hi_i     = hv;
    lo_i     = lv;
    cancel_i = (cancel_at == 0);
    #1;
    check("stall_at_N", stall_o, is_div && accepted);
    check("we_at_N", hilo_we_o, 0);

    for (int k = 1; k <= window; k++) begin
      @(negedge clk);
      busy = (k <= busy_end) && (cancel_at < 0 || k <= cancel_at);
      // Stray requests while busy must be ignored.
      start_i  = busy ? 1'($urandom_range(0, 1)) : 1'b0;
      op_i     = 3'($urandom_range(0, 7));
      opa_i    = $urandom;
      opb_i    = $urandom;
      hi_i     = $urandom;
      lo_i     = $urandom;
      cancel_i = (k == cancel_at);
      #1;
      exp_we    = (k == wc);
      exp_stall = divrun && accepted && (k <= 32) && (cancel_at < 0 || k <= cancel_at);
      if (exp_we) begin
        last_hi = eh;
        last_lo = el;
      end
      check("we", hilo_we_o, exp_we);
      check("stall", stall_o, exp_stall);
      check("hi", hi_o, last_hi);
      check("lo", lo_o, last_lo);
    end
    @(negedge clk);
    start_i  = 1'b0;
    cancel_i = 1'b0;
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    int          c;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_we", hilo_we_o, 0);
    check("rst_stall", stall_o, 0);
    check("rst_hi", hi_o, 0);
    check("rst_lo", lo_o, 0);
    rst = 1'b0;

    // Directed cases
    run_op(3'b000, 32'hFFFF_FFFE, 32'd3, 32'h0, 32'h0, -1);         // T1
    run_op(3'b011, 32'd100, 32'd7, 32'h0, 32'h0, -1);               // T2
    run_op(3'b010, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0, -1);         // T3
    run_op(3'b010, 32'd5, 32'd0, 32'h0, 32'h0, -1);                 // T4
    run_op(3'b011, 32'd1000, 32'd9, 32'h0, 32'h0, 10);              // T5
    run_op(3'b001, 32'd2, 32'd3, 32'h0, 32'h0, -1);
    run_op(3'b100, 32'h1234, 32'h0, 32'h55, 32'hAA, -1);            // T6
    run_op(3'b110, 32'd2, 32'd3, 32'h0, 32'hFFFF_FFFF, -1);
    run_op(3'b111, 32'd2, 32'd3, 32'h0, 32'h0, -1);
    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, -1); // wrap case
    run_op(3'b101, 32'hCAFE, 32'h0, 32'h77, 32'h88, -1);
    run_op(3'b000, 32'd7, 32'd7, 32'h0, 32'h0, 0);                  // cancel beats start
    run_op(3'b011, 32'd50, 32'd5, 32'h0, 32'h0, 32);                // cancel on last iteration

    // Randomized traffic
    for (int i = 0; i < 120; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = rand_opnd();
      b  = rand_opnd();
      c  = -1;
      if ($urandom_range(0, 9) == 0) c = 0;
      else if ((op == 3'b010 || op == 3'b011) && b != 0 && $urandom_range(0, 4) == 0)
        c = $urandom_range(1, 32);
      run_op(op, a, b, $urandom, $urandom, c);
    end

    // Flush in the write cycle of a single-cycle op kills the strobe
    @(negedge clk);
    start_i = 1'b1; op_i = 3'b000; opa_i = 32'd5; opb_i = 32'd7; cancel_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0; cancel_i = 1'b1;
    #1;
    check("cancel_pending_we", hilo_we_o, 0);
    @(negedge clk);
    cancel_i = 1'b0;
    #1;
    check("cancel_pending_we_after", hilo_we_o, 0);

    // Reset in the middle of a divide
    @(negedge clk);
    start_i = 1'b1; op_i = 3'b011; opa_i = 32'd1000; opb_i = 32'd3;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    #1;
    check("mid_div_stall", stall_o, 1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("rst_mid_we", hilo_we_o, 0);
    check("rst_mid_stall", stall_o, 0);
    check("rst_mid_hi", hi_o, 0);
    check("rst_mid_lo", lo_o, 0);
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      check("post_rst_we", hilo_we_o, 0);
      check("post_rst_stall", stall_o, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
